// File: rtl/register_file_mp.sv
// Multi-port register file with a per-register pending scoreboard for RAW hazard detection.
// Latency: reads and rbusy are combinational; writes, reservations and pend_cnt update at the CLK edge.
// Backpressure: none; every write or reserve is accepted. Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module register_file_mp #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NWRITE-1:0]       wen,
    input  logic [NWRITE*AW-1:0]    wsel,
    input  logic [NWRITE*WIDTH-1:0] wdat,
    input  logic                    resv_en,
    input  logic [AW-1:0]           resv_sel,
    input  logic [NREAD*AW-1:0]     rsel,
    output logic [NREAD*WIDTH-1:0]  rdat,
    output logic [NREAD-1:0]        rbusy,
    output logic [AW:0]             pend_cnt
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pending_q, pending_d;
    logic [AW:0]      pend_cnt_q, pend_cnt_d;

    // Register 0 is hardwired when ZERO_REG is set.
    function automatic logic is_zero(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Next-state data: ports applied in ascending order so the highest port wins a collision.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int k = 0; k < NWRITE; k++) begin
            if (wen[k] && !is_zero(wsel[k*AW +: AW])) begin
                regs_d[wsel[k*AW +: AW]] = wdat[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state scoreboard: reservation beats writeback clear; count follows the new bits.
    always_comb begin
        pending_d  = pending_q;
        pend_cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (resv_en && (resv_sel == AW'(r)) && !is_zero(AW'(r))) begin
                pending_d[r] = 1'b1;
            end else begin
                for (int k = 0; k < NWRITE; k++) begin
                    if (wen[k] && (wsel[k*AW +: AW] == AW'(r))) begin
                        pending_d[r] = 1'b0;
                    end
                end
            end
            pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, pending_d[r]};
        end
    end

    // State registers with synchronous reset that discards data and reservations.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Read ports: stored value and pending bit, optionally overridden by a same-cycle write.
    always_comb begin
        rdat  = '0;
        rbusy = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (!is_zero(rsel[p*AW +: AW])) begin
                rdat[p*WIDTH +: WIDTH] = regs_q[rsel[p*AW +: AW]];
                rbusy[p]               = pending_q[rsel[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < NWRITE; k++) begin
                    if (wen[k] && (wsel[k*AW +: AW] == rsel[p*AW +: AW])) begin
                        rdat[p*WIDTH +: WIDTH] = wdat[k*WIDTH +: WIDTH];
                        // A writeback retires the hazard unless the same register is re-reserved now.
                        if (!(resv_en && (resv_sel == rsel[p*AW +: AW]))) begin
                            rbusy[p] = 1'b0;
                        end
                    end
                end
`endif
            end
        end
    end

    assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

    localparam int WIDTH  = 32;
    localparam int NREGS  = 32;
    localparam int AW     = 5;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                    CLK = 1'b0;
    logic                    RST;
    logic [NWRITE-1:0]       wen;
    logic [NWRITE*AW-1:0]    wsel;
    logic [NWRITE*WIDTH-1:0] wdat;
    logic                    resv_en;
    logic [AW-1:0]           resv_sel;
    logic [NREAD*AW-1:0]     rsel;
    logic [NREAD*WIDTH-1:0]  rdat;
    logic [NREAD-1:0]        rbusy;
    logic [AW:0]             pend_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    register_file_mp #(
        .WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .ZERO_REG(1)
    ) dut (
        .CLK(CLK), .RST(RST), .wen(wen), .wsel(wsel), .wdat(wdat),
        .resv_en(resv_en), .resv_sel(resv_sel), .rsel(rsel),
        .rdat(rdat), .rbusy(rbusy), .pend_cnt(pend_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wen      = '0;
        wsel     = '0;
        wdat     = '0;
        resv_en  = 1'b0;
        resv_sel = '0;
    endtask

    // Advance past the next rising edge; inputs are then driven for the following cycle.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int port, input logic [AW-1:0] a, input logic [31:0] d);
        wen[port]               = 1'b1;
        wsel[port*AW +: AW]     = a;
        wdat[port*WIDTH +: WIDTH] = d;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rsel = {a1, a0};
    endtask

    initial begin
        RST = 1'b1;
        idle();
        rsel = '0;
        tick();
        tick();
        RST = 1'b0;
        rd(5, 0);
        #1;
        check("por_rdat0", rdat[31:0], 32'h0);
        check("por_pend", 32'(pend_cnt), 32'd0);

        // Reset clears stored data and pending bits
        idle();
        wr(0, 5, 32'hDEADBEEF);
        resv_en = 1'b1; resv_sel = 6;
        tick();
        idle();
        #1;
        check("pre_rst_rdat0", rdat[31:0], 32'hDEADBEEF);
        check("pre_rst_pend", 32'(pend_cnt), 32'd1);
        RST = 1'b1;
        wr(0, 5, 32'h11111111);
        resv_en = 1'b1; resv_sel = 5;
        tick();
        RST = 1'b0;
        idle();
        #1;
        check("rst_rdat0", rdat[31:0], 32'h0);
        check("rst_rbusy0", 32'(rbusy[0]), 32'd0);
        check("rst_pend", 32'(pend_cnt), 32'd0);

        // Register 0 ignores writes and reservations
        wr(0, 0, 32'h12345678);
        resv_en = 1'b1; resv_sel = 0;
        rd(0, 0);
        tick();
        idle();
        #1;
        check("zero_rdat", rdat[31:0], 32'h0);
        check("zero_rbusy", 32'(rbusy[0]), 32'd0);
        check("zero_pend", 32'(pend_cnt), 32'd0);

        // Reservation lifecycle on r7
        rd(7, 0);
        resv_en = 1'b1; resv_sel = 7;
        #1;
        check("life_c1_rbusy", 32'(rbusy[0]), 32'd0);
        tick();
        idle();
        #1;
        check("life_c2_rbusy", 32'(rbusy[0]), 32'd1);
        check("life_c2_pend", 32'(pend_cnt), 32'd1);
        tick();
        #1;
        check("life_c3_rbusy", 32'(rbusy[0]), 32'd1);
        check("life_c3_pend", 32'(pend_cnt), 32'd1);
        tick();
        wr(0, 7, 32'hCAFEF00D);
        #1;
        check("life_c4_rbusy", 32'(rbusy[0]), BYP ? 32'd0 : 32'd1);
        check("life_c4_pend", 32'(pend_cnt), 32'd1);
        check("life_c4_rdat", rdat[31:0], BYP ? 32'hCAFEF00D : 32'h0);
        tick();
        idle();
        #1;
        check("life_c5_rbusy", 32'(rbusy[0]), 32'd0);
        check("life_c5_pend", 32'(pend_cnt), 32'd0);
        check("life_c5_rdat", rdat[31:0], 32'hCAFEF00D);

        // Simultaneous reserve and write on pending r9
        rd(9, 0);
        resv_en = 1'b1; resv_sel = 9;
        tick();
        idle();
        #1;
        check("sim_pre_pend", 32'(pend_cnt), 32'd1);
        wr(0, 9, 32'h1);
        resv_en = 1'b1; resv_sel = 9;
        #1;
        check("sim_same_rbusy", 32'(rbusy[0]), 32'd1);
        tick();
        idle();
        #1;
        check("sim_rdat", rdat[31:0], 32'h1);
        check("sim_rbusy", 32'(rbusy[0]), 32'd1);
        check("sim_pend", 32'(pend_cnt), 32'd1);

        // Write-port collision: port 1 wins; r3 not pending so count is unchanged
        wr(0, 3, 32'h0000AAAA);
        wr(1, 3, 32'h00005555);
        rd(3, 0);
        tick();
        idle();
        #1;
        check("coll_rdat", rdat[31:0], 32'h00005555);
        check("coll_pend", 32'(pend_cnt), 32'd1);

        // Port 1 writeback clears a reservation; two pending then one
        resv_en = 1'b1; resv_sel = 10;
        rd(9, 10);
        tick();
        idle();
        #1;
        check("p1_pend2", 32'(pend_cnt), 32'd2);
        check("p1_rbusy1_pre", 32'(rbusy[1]), 32'd1);
        wr(1, 10, 32'h00000077);
        tick();
        idle();
        #1;
        check("p1_pend1", 32'(pend_cnt), 32'd1);
        check("p1_rbusy1", 32'(rbusy[1]), 32'd0);
        check("p1_rdat1", rdat[63:32], 32'h00000077);
        check("p1_rbusy0", 32'(rbusy[0]), 32'd1);

        // Same-cycle read of a register being written
        wr(0, 4, 32'h00001111);
        tick();
        idle();
        rd(0, 4);
        wr(0, 4, 32'h0000BEEF);
        #1;
        check("byp_same", rdat[63:32], BYP ? 32'h0000BEEF : 32'h00001111);
        tick();
        idle();
        #1;
        check("byp_next", rdat[63:32], 32'h0000BEEF);
        check("byp_r0_port0", rdat[31:0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
